mdc_minor_engine: RTL and testbench

Parametrised successor of the MDC matrix block. It accepts an N×N matrix of Hamming-SEC-protected signed entries as a single-beat-per-cycle stream and corrects any single-bit error in each word. It computes all (N−1)² adjacent 2×2 minors, either determinants or permanents, with one shared multiply-accumulate path. The packed result is returned in one output beat, together with a corrected-word count. It sits directly behind the PATTERN-driven input stream, in the position the MDC block occupies.

---
 rtl/mdc_pkg.sv | 52 +++++
 rtl/hamming_sec_dec.sv | 47 ++++
 rtl/mdc_minor_engine.sv | 154 +++++++++++++++
 tb/tb_mdc_minor_engine.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mdc_pkg.sv
// rtl/mdc_pkg.sv - shared types and derived-width helpers for the minor engine
//
// Purpose : FSM state type, width formulas derived from the block parameters,
//           and the Hamming data-bit position lookup.
// Ports   : none (package)

package mdc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CALC,
        ST_OUT
    } state_t;

    // Coded word width: data plus parity bits.
    function automatic int code_w(input int data_w, input int par_w);
        return data_w + par_w;
    endfunction

    // Number of adjacent 2x2 minors in an n x n matrix.
    function automatic int minor_cnt(input int n);
        return (n - 1) * (n - 1);
    endfunction

    // Exact width of ad +/- bc for data_w-bit signed operands.
    function automatic int det_w(input int data_w);
        return 2 * data_w + 1;
    endfunction

    // Width of a counter able to hold 0..n*n.
    function automatic int cnt_w(input int n);
        return $clog2(n * n + 1);
    endfunction

    // Codeword position (1-based) of the p-th data bit, p = 0 being the data MSB.
    // Data bits occupy the non-power-of-two positions in ascending order.
    function automatic int data_pos(input int p);
        int pos;
        int seen;
        pos  = 0;
        seen = 0;
        for (int q = 1; q < 64; q++) begin
            if ((q & (q - 1)) != 0) begin
                if (seen == p && pos == 0) pos = q;
                seen++;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/hamming_sec_dec.sv
// rtl/hamming_sec_dec.sv - combinational Hamming single-error-correcting decoder
//
// Purpose : computes the syndrome of one codeword, flips the addressed bit when
//           it lies inside the word, and extracts the data bits.
// Ports   : i_code    in  DATA_W+PAR_W  codeword, i_code[MSB] is position 1
//           data      out DATA_W        corrected data, lowest data position = MSB
//           corrected out 1             syndrome was non-zero

module hamming_sec_dec
    import mdc_pkg::*;
#(
    parameter int DATA_W = 11,
    parameter int PAR_W  = 4
) (
    input  logic [DATA_W+PAR_W-1:0] i_code,
    output logic [DATA_W-1:0]       data,
    output logic                    corrected
);

    localparam int CODE_W = code_w(DATA_W, PAR_W);

    logic [PAR_W-1:0]  w_syn;
    logic [CODE_W-1:0] w_fixed;

    // Syndrome is the XOR of the positions of every set bit.
    always_comb begin
        w_syn = '0;
        for (int q = 1; q <= CODE_W; q++) begin
            if (i_code[CODE_W-q]) w_syn = w_syn ^ PAR_W'(q);
        end
    end

    // A syndrome beyond CODE_W (imperfect codes) matches no position: no flip.
    always_comb begin
        w_fixed = i_code;
        for (int q = 1; q <= CODE_W; q++) begin
            if (int'(w_syn) == q) w_fixed[CODE_W-q] = ~i_code[CODE_W-q];
        end
    end

    assign corrected = (w_syn != '0);

    for (genvar p = 0; p < DATA_W; p++) begin : g_data
        assign data[DATA_W-1-p] = w_fixed[CODE_W-data_pos(p)];
    end

endmodule

// File: rtl/mdc_minor_engine.sv
// rtl/mdc_minor_engine.sv - streams an N x N Hamming-coded matrix, returns all 2x2 minors
//
// Purpose : loads N*N corrected entries, computes one adjacent 2x2 determinant
//           or permanent per cycle on a shared multiplier pair, and presents the
//           packed result with the count of corrected words on a one-cycle strobe.
// Ports   : clk, rst_n (async active-low)
//           in_valid, in_data[CODE_W], in_mode   input stream, row-major
//           out_valid                           result strobe
//           out_data[K*DET_W]                   minor 0 in the MSBs
//           out_corr[CNT_W]                     words with non-zero syndrome

module mdc_minor_engine
    import mdc_pkg::*;
#(
    parameter  int DATA_W = 11,
    parameter  int PAR_W  = 4,
    parameter  int N      = 4,
    localparam int CODE_W = code_w(DATA_W, PAR_W),
    localparam int K      = minor_cnt(N),
    localparam int DET_W  = det_w(DATA_W),
    localparam int CNT_W  = cnt_w(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [CODE_W-1:0]    in_data,
    input  logic                 in_mode,
    output logic                 out_valid,
    output logic [K*DET_W-1:0]   out_data,
    output logic [CNT_W-1:0]     out_corr
);

    localparam int IW   = $clog2(N * N);
    localparam int RC_W = $clog2(N);

    state_t                    r_state;
    logic signed [DATA_W-1:0]  r_mat [N*N];
    logic [IW-1:0]             r_idx;
    logic [RC_W-1:0]           r_row;
    logic [RC_W-1:0]           r_col;
    logic                      r_mode;
    logic [CNT_W-1:0]          r_cnt;
    logic [K*DET_W-1:0]        r_pack;
    logic                      r_out_valid;
    logic [K*DET_W-1:0]        r_out_data;
    logic [CNT_W-1:0]          r_out_corr;

    logic [DATA_W-1:0]         w_dec_data;
    logic                      w_dec_corr;
    logic [IW-1:0]             w_base;
    logic signed [DET_W-1:0]   w_a;
    logic signed [DET_W-1:0]   w_b;
    logic signed [DET_W-1:0]   w_c;
    logic signed [DET_W-1:0]   w_d;
    logic signed [DET_W-1:0]   w_ad;
    logic signed [DET_W-1:0]   w_bc;
    logic signed [DET_W-1:0]   w_minor;
    logic [K*DET_W-1:0]        w_pack_next;
    logic                      w_last_minor;

    hamming_sec_dec #(
        .DATA_W (DATA_W),
        .PAR_W  (PAR_W)
    ) u_dec (
        .i_code    (in_data),
        .data      (w_dec_data),
        .corrected (w_dec_corr)
    );

    // Top-left corner of the current 2x2 window.
    assign w_base = IW'(int'(r_row) * N + int'(r_col));

    // Sized casts of signed operands sign-extend to DET_W, so the products and
    // the final add/subtract are exact without further guarding.
    assign w_a = DET_W'(r_mat[w_base]);
    assign w_b = DET_W'(r_mat[w_base + IW'(1)]);
    assign w_c = DET_W'(r_mat[w_base + IW'(N)]);
    assign w_d = DET_W'(r_mat[w_base + IW'(N + 1)]);

    assign w_ad    = w_a * w_d;
    assign w_bc    = w_b * w_c;
    assign w_minor = r_mode ? (w_ad + w_bc) : (w_ad - w_bc);

    // Shifting left leaves the first minor computed in the MSBs after K steps.
    assign w_pack_next  = (r_pack << DET_W) | (K*DET_W)'($unsigned(w_minor));
    assign w_last_minor = (r_row == RC_W'(N - 2)) && (r_col == RC_W'(N - 2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            for (int i = 0; i < N * N; i++) r_mat[i] <= '0;
            r_idx       <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_mode      <= 1'b0;
            r_cnt       <= '0;
            r_pack      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_corr  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_mat[0] <= w_dec_data;
                        r_mode   <= in_mode;
                        r_cnt    <= CNT_W'(w_dec_corr);
                        r_idx    <= IW'(1);
                        r_state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!in_valid) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_mat[r_idx] <= w_dec_data;
                        r_cnt        <= r_cnt + CNT_W'(w_dec_corr);
                        r_idx        <= r_idx + IW'(1);
                        if (r_idx == IW'(N * N - 1)) begin
                            r_row   <= '0;
                            r_col   <= '0;
                            r_state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    r_pack <= w_pack_next;
                    if (r_col == RC_W'(N - 2)) begin
                        r_col <= '0;
                        r_row <= r_row + RC_W'(1);
                    end else begin
                        r_col <= r_col + RC_W'(1);
                    end
                    if (w_last_minor) begin
                        r_out_data  <= w_pack_next;
                        r_out_corr  <= r_cnt;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    r_out_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_corr  = r_out_corr;

endmodule

// File: tb/tb_mdc_minor_engine.sv
// tb/tb_mdc_minor_engine.sv - self-checking bench for mdc_minor_engine (4x4/11-bit and 3x3/4-bit)

module tb_mdc_minor_engine;

    localparam int DW  = 11;
    localparam int PW  = 4;
    localparam int NA  = 4;
    localparam int CWA = 15;
    localparam int KA  = 9;
    localparam int DTA = 23;

    localparam int DWB = 4;
    localparam int PWB = 3;
    localparam int NB  = 3;
    localparam int CWB = 7;
    localparam int KB  = 4;
    localparam int DTB = 9;

    typedef struct {
        int           due;
        logic [255:0] data;
        int           corr;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic               in_valid = 1'b0;
    logic               in_mode  = 1'b0;
    logic [CWA-1:0]     in_data  = '0;
    logic               out_valid;
    logic [KA*DTA-1:0]  out_data;
    logic [4:0]         out_corr;

    logic               b_in_valid = 1'b0;
    logic               b_in_mode  = 1'b0;
    logic [CWB-1:0]     b_in_data  = '0;
    logic               b_out_valid;
    logic [KB*DTB-1:0]  b_out_data;
    logic [3:0]         b_out_corr;

    mdc_minor_engine #(.DATA_W(DW), .PAR_W(PW), .N(NA)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid), .out_data(out_data), .out_corr(out_corr)
    );

    mdc_minor_engine #(.DATA_W(DWB), .PAR_W(PWB), .N(NB)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_data(b_in_data), .in_mode(b_in_mode),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_corr(b_out_corr)
    );

    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc   = 0;
    exp_t         qa[$];
    exp_t         qb[$];
    logic [255:0] last_a = '0;
    int           last_a_corr = 0;
    int           last_a_cyc  = 0;
    logic [255:0] last_b = '0;
    int           last_b_cyc  = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    // Standard Hamming encoder: data MSB-first into non-power-of-two positions,
    // then parity bits chosen so the syndrome is zero.
    function automatic logic [63:0] enc(input int val, input int dw, input int pw);
        logic [63:0] w;
        int cw, p, syn;
        w = '0; cw = dw + pw; p = dw - 1; syn = 0;
        for (int q = 1; q <= cw; q++) begin
            if ((q & (q - 1)) != 0) begin
                w[cw-q] = val[p];
                p--;
            end
        end
        for (int q = 1; q <= cw; q++) if (w[cw-q]) syn = syn ^ q;
        for (int j = 0; j < pw; j++) if (syn[j]) w[cw-(1<<j)] = 1'b1;
        return w;
    endfunction

    // Minor k = r*(n-1)+c placed at bits (K-1-k)*dtw upward.
    function automatic logic [255:0] model(input int m[16], input int n, input bit mode, input int dtw);
        logic [255:0] r;
        longint a, b, c, d, v;
        int k, kk;
        r = '0; kk = (n - 1) * (n - 1);
        for (int i = 0; i < n - 1; i++) begin
            for (int j = 0; j < n - 1; j++) begin
                a = m[i*n+j]; b = m[i*n+j+1]; c = m[(i+1)*n+j]; d = m[(i+1)*n+j+1];
                v = mode ? (a * d + b * c) : (a * d - b * c);
                k = i * (n - 1) + j;
                for (int bt = 0; bt < dtw; bt++) r[(kk-1-k)*dtw+bt] = v[bt];
            end
        end
        return r;
    endfunction

    task automatic send_a(input int m[16], input bit mode, input int flip[16], input int nbeats, output int t0);
        logic [CWA-1:0] w;
        int nc;
        nc = 0;
        t0 = cyc;
        for (int i = 0; i < nbeats; i++) begin
            w = CWA'(enc(m[i], DW, PW));
            if (flip[i] != 0) begin
                w[CWA-flip[i]] = ~w[CWA-flip[i]];
                nc++;
            end
            in_valid = 1'b1; in_mode = mode; in_data = w;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_mode = 1'b0; in_data = '0;
        if (nbeats == NA * NA) qa.push_back('{t0 + NA*NA + KA, model(m, NA, mode, DTA), nc});
    endtask

    task automatic send_b(input int m[16], input bit mode, output int t0);
        t0 = cyc;
        for (int i = 0; i < NB * NB; i++) begin
            b_in_valid = 1'b1; b_in_mode = mode; b_in_data = CWB'(enc(m[i], DWB, PWB));
            @(posedge clk); #1;
        end
        b_in_valid = 1'b0; b_in_mode = 1'b0; b_in_data = '0;
        qb.push_back('{t0 + NB*NB + KB, model(m, NB, mode, DTB), 0});
    endtask

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Compare processes: strobe exactly at the model's due cycle, quiet otherwise.
    initial forever begin
        @(negedge clk);
        if (qa.size() > 0 && qa[0].due == cyc) begin
            chk("a_out_valid", 256'(out_valid), 256'(1));
            chk("a_out_data", 256'(out_data), qa[0].data);
            chk("a_out_corr", 256'(out_corr), 256'(qa[0].corr));
            last_a = 256'(out_data); last_a_corr = int'(out_corr); last_a_cyc = cyc;
            void'(qa.pop_front());
        end else begin
            chk("a_out_valid_idle", 256'(out_valid), 256'(0));
        end
    end

    initial forever begin
        @(negedge clk);
        if (qb.size() > 0 && qb[0].due == cyc) begin
            chk("b_out_valid", 256'(b_out_valid), 256'(1));
            chk("b_out_data", 256'(b_out_data), qb[0].data);
            chk("b_out_corr", 256'(b_out_corr), 256'(qb[0].corr));
            last_b = 256'(b_out_data); last_b_cyc = cyc;
            void'(qb.pop_front());
        end else begin
            chk("b_out_valid_idle", 256'(b_out_valid), 256'(0));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    int id4[16]   = '{1,0,0,0, 0,1,0,0, 0,0,1,0, 0,0,0,1};
    int ext4[16]  = '{-1024,-1024,0,0, 1023,-1024,0,0, 0,0,0,0, 0,0,0,0};
    int sev3[16]  = '{7,7,7, 7,7,7, 7,7,7, 0,0,0,0,0,0,0};
    int noflip[16] = '{default: 0};
    int flips[16]  = '{1,0,0,8, 0,15,0,0, 0,0,6,0, 0,0,0,3};
    logic [255:0] id_lit;
    logic [255:0] b_lit;
    int t0;

    initial begin
        id_lit = 256'({23'd1,23'd0,23'd0,23'd0,23'd1,23'd0,23'd0,23'd0,23'd1});
        b_lit  = 256'({9'd98,9'd98,9'd98,9'd98});

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_out_data", 256'(out_data), 256'(0));
        chk("reset_out_corr", 256'(out_corr), 256'(0));
        chk("reset_out_valid", 256'(out_valid), 256'(0));
        @(posedge clk); #1;

        // Clean identity, determinant.
        send_a(id4, 1'b0, noflip, 16, t0);
        repeat (KA + 3) @(posedge clk); #1;
        chk("id_minors", last_a, id_lit);
        chk("id_corr", 256'(last_a_corr), 256'(0));
        chk("id_latency", 256'(last_a_cyc - t0), 256'(25));

        // Extreme operands, determinant then permanent.
        send_a(ext4, 1'b0, noflip, 16, t0);
        repeat (KA + 3) @(posedge clk); #1;
        chk("ext_det_minor0", 256'(last_a[8*DTA +: DTA]), 256'(23'd2096128));
        send_a(ext4, 1'b1, noflip, 16, t0);
        repeat (KA + 3) @(posedge clk); #1;
        chk("ext_perm_minor0", 256'(last_a[8*DTA +: DTA]), 256'(23'd1024));

        // Single-bit errors in five words, incl. position 1 and parity position 8.
        send_a(id4, 1'b0, flips, 16, t0);
        repeat (KA + 3) @(posedge clk); #1;
        chk("flip_minors", last_a, id_lit);
        chk("flip_corr", 256'(last_a_corr), 256'(5));

        // Aborted load, then a clean matrix: only one strobe expected.
        send_a(id4, 1'b1, noflip, 7, t0);
        @(posedge clk); #1;
        send_a(id4, 1'b0, noflip, 16, t0);
        repeat (KA + 3) @(posedge clk); #1;
        chk("abort_minors", last_a, id_lit);
        chk("abort_latency", 256'(last_a_cyc - t0), 256'(25));

        // Reset while computing: outputs clear at once, strobe suppressed.
        send_a(ext4, 1'b0, noflip, 16, t0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        qa.delete();
        #1;
        chk("rst_calc_valid", 256'(out_valid), 256'(0));
        chk("rst_calc_data", 256'(out_data), 256'(0));
        chk("rst_calc_corr", 256'(out_corr), 256'(0));
        repeat (KA + 3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        send_a(id4, 1'b0, flips, 16, t0);
        repeat (KA + 3) @(posedge clk); #1;
        chk("post_rst_minors", last_a, id_lit);
        chk("post_rst_latency", 256'(last_a_cyc - t0), 256'(25));

        // Small configuration: 3x3, 4-bit entries, permanent.
        send_b(sev3, 1'b1, t0);
        repeat (KB + 3) @(posedge clk); #1;
        chk("b_minors", last_b, b_lit);
        chk("b_latency", 256'(last_b_cyc - t0), 256'(13));

        repeat (3) @(posedge clk); #1;
        chk("a_queue_drained", 256'(qa.size()), 256'(0));
        chk("b_queue_drained", 256'(qb.size()), 256'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
